// File: rtl/dice_pkg.sv
// Shared types and constants for the multi-player dice game controller.
package dice_pkg;

   // Controller state encoding; the numeric values appear on the state output.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ROLL   = 3'd1,
      CHOOSE = 3'd2,
      UPDATE = 3'd3,
      WON    = 3'd4,
      OVER   = 3'd5
   } state_t;

   // Meaning of the choice switch when a roll is confirmed.
   localparam logic CHOICE_BANK    = 1'b1;
   localparam logic CHOICE_DISCARD = 1'b0;

   // Width of a player index; never narrower than one bit.
   function automatic int plr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dice_roller.sv
// Free-running die counter (1..FACES) with a latch that captures the roll.
module dice_roller #(
   parameter int FACES = 6,
   parameter int DIE_W = $clog2(FACES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             hold,
   input  logic             clear,
   input  logic             latch,
   output logic [DIE_W-1:0] value
);

   logic [DIE_W-1:0] count_reg;

   // Counter advances while enabled and not held, wrapping FACES -> 1;
   // latch copies the current count to the visible roll value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= DIE_W'(1);
         value     <= '0;
      end else begin
         if (clear) begin
            count_reg <= DIE_W'(1);
         end else if (enable && !hold) begin
            count_reg <= (count_reg == DIE_W'(FACES)) ? DIE_W'(1) : count_reg + DIE_W'(1);
         end
         if (latch) begin
            value <= count_reg;
         end
      end
   end

endmodule

// File: rtl/dice_game_ctrl.sv
// N-player dice race controller: roll, bank or discard, hit TARGET exactly.
module dice_game_ctrl
   import dice_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int FACES       = 6,
   parameter int TARGET      = 15,
   parameter int MAX_ROUNDS  = 8,
   localparam int SCORE_W    = $clog2(TARGET + 1),
   localparam int DIE_W      = $clog2(FACES + 1),
   localparam int PLR_W      = plr_width(NUM_PLAYERS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           btn,
   input  logic                           choice,
   output logic [2:0]                     state,
   output logic [DIE_W-1:0]               num,
   output logic [PLR_W-1:0]               cur_player,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic [3:0]                     rounds_left,
   output logic                           busted,
   output logic                           won,
   output logic [PLR_W-1:0]               winner,
   output logic                           game_over
);

   state_t               state_reg;
   logic                 btn_q;
   logic                 choice_q;
   logic [SCORE_W-1:0]   score_reg [NUM_PLAYERS];
   logic                 rise;
   logic                 fall;
   logic [SCORE_W:0]     sum;

   assign rise  = btn & ~btn_q;
   assign fall  = ~btn & btn_q;
   assign state = state_reg;

   // One extra bit so an overshoot past TARGET is visible without wrapping.
   assign sum = {1'b0, score_reg[cur_player]} + {{(SCORE_W + 1 - DIE_W){1'b0}}, num};

   // Present the score array as one packed bus for the display logic.
   generate
      for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_scores
         assign scores[gi*SCORE_W +: SCORE_W] = score_reg[gi];
      end
   endgenerate

   dice_roller #(
      .FACES (FACES),
      .DIE_W (DIE_W)
   ) u_roller (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable ((state_reg == ROLL) && btn),
      .hold   (fall),
      .clear  ((state_reg == IDLE) && fall),
      .latch  ((state_reg == ROLL) && fall),
      .value  (num)
   );

   // Game FSM with scores, turn rotation, round count and registered flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         btn_q       <= 1'b0;
         choice_q    <= CHOICE_DISCARD;
         cur_player  <= '0;
         rounds_left <= 4'(MAX_ROUNDS);
         busted      <= 1'b0;
         won         <= 1'b0;
         winner      <= '0;
         game_over   <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            score_reg[p] <= '0;
         end
      end else begin
         btn_q  <= btn;
         busted <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (fall) begin
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     score_reg[p] <= '0;
                  end
                  cur_player  <= '0;
                  rounds_left <= 4'(MAX_ROUNDS);
                  state_reg   <= ROLL;
               end
            end
            ROLL: begin
               if (fall) begin
                  state_reg <= CHOOSE;
               end
            end
            CHOOSE: begin
               if (rise) begin
                  choice_q  <= choice;
                  state_reg <= UPDATE;
               end
            end
            UPDATE: begin
               if ((choice_q == CHOICE_BANK) && (sum == (SCORE_W + 1)'(TARGET))) begin
                  score_reg[cur_player] <= sum[SCORE_W-1:0];
                  winner                <= cur_player;
                  won                   <= 1'b1;
                  game_over             <= 1'b1;
                  state_reg             <= WON;
               end else begin
                  if (choice_q == CHOICE_BANK) begin
                     if (sum > (SCORE_W + 1)'(TARGET)) begin
                        score_reg[cur_player] <= '0;
                        busted                <= 1'b1;
                     end else begin
                        score_reg[cur_player] <= sum[SCORE_W-1:0];
                     end
                  end
                  if (cur_player == PLR_W'(NUM_PLAYERS - 1)) begin
                     cur_player  <= '0;
                     rounds_left <= rounds_left - 4'd1;
                     if (rounds_left == 4'd1) begin
                        game_over <= 1'b1;
                        state_reg <= OVER;
                     end else begin
                        state_reg <= ROLL;
                     end
                  end else begin
                     cur_player <= cur_player + PLR_W'(1);
                     state_reg  <= ROLL;
                  end
               end
            end
            WON, OVER: begin
               if (fall) begin
                  won       <= 1'b0;
                  winner    <= '0;
                  game_over <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
